regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the single-port register file between two requesters: the SPI bridge write path (toggle-signalled) and a core-side requester (valid/ready handshake).
- Resynchronises the bridge's wr_toggle/wr_addr/wr_data into the sclk domain.
- Arbitrates round-robin and sequences each register-file access through a small FSM.
- Sits between spi_bridge and the register file.

Parameters:
- ADDR_W, 6, register address width.
- DATA_W, 8, register data width.
- NUM_REGS, 64, number of implemented registers; addresses >= NUM_REGS are out of range.
- SYNC_STAGES, 2, flop stages on the wr_toggle synchroniser (>= 2).

Ports:
- sclk  in  1  block clock, free-running.
- rst_n  in  1  asynchronous active-low reset.
- spi_wr_toggle  in  1  bridge write event; each edge is one write.
- spi_wr_addr  in  ADDR_W  bridge write address; stable while the toggle is in flight.
- spi_wr_data  in  DATA_W  bridge write data; stable while the toggle is in flight.
- core_req  in  1  core access request.
- core_we  in  1  core access type: 1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_ready  out  1  core request accepted this cycle.
- core_rvalid  out  1  core read data valid, 1-cycle pulse.
- core_rdata  out  DATA_W  core read data.
- core_err  out  1  core out-of-range access; pulses with ready (write) or rvalid (read).
- rf_en  out  1  register-file access strobe.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_W  register-file address.
- rf_wdata  out  DATA_W  register-file write data.
- rf_rdata  in  DATA_W  register-file read data; valid 1 cycle after rf_en with rf_we = 0.
- spi_ovf  out  1  sticky: a bridge write was lost.
- busy  out  1  FSM not in IDLE, or a bridge write is pending.

Behaviour:
- Reset: every output is 0. Synchroniser flops, pending flag, round-robin pointer (points to SPI) and FSM (IDLE) all clear.
- Bridge path:
  - wr_toggle passes through SYNC_STAGES flops; an XOR of the last two stages marks a detected edge.
  - On a detected edge, spi_wr_addr and spi_wr_data are captured into a holding register and spi_pend is set.
  - Edge detected while spi_pend = 1: the held write is kept, the new write is discarded and spi_ovf is set.
  - spi_ovf stays set until reset.
- Core path: requests are accepted only in IDLE. core_ready pulses 1 cycle in the IDLE cycle that grants core. Inputs are sampled in that cycle.
- Arbitration in IDLE:
  - Only one requester asserted: it wins.
  - Both asserted: the one the round-robin pointer selects wins; the pointer then moves to the other requester.
  - A single winner also moves the pointer to the other requester.
- FSM states: IDLE, WRITE, READ, RDATA.
  - IDLE -> WRITE: SPI grant, or core write grant.
  - IDLE -> READ: core read grant.
  - WRITE: rf_en = 1, rf_we = 1 for 1 cycle. An SPI write clears spi_pend here. -> IDLE.
  - READ: rf_en = 1, rf_we = 0 for 1 cycle. -> RDATA.
  - RDATA: core_rdata <= rf_rdata, core_rvalid = 1 for 1 cycle. -> IDLE.
- Latency (in-range access):
  - Core write: ready at grant cycle; rf write on grant+1.
  - Core read: ready at grant cycle; rf_en on grant+1; rvalid on grant+2.
  - SPI write: toggle edge to rf_en = SYNC_STAGES + 1 cycles minimum (more if core holds the port).
- Out-of-range address (>= NUM_REGS):
  - Core write: rf_en stays 0; core_err pulses with core_ready.
  - Core read: rf_en stays 0; in RDATA, core_rdata = 0 and core_err pulses with core_rvalid.
  - SPI write: the pending write is dropped silently; spi_pend clears with no rf cycle.
- rf_addr, rf_wdata and rf_we hold their last values when rf_en = 0.
- Simultaneous events: an edge detected in the same cycle spi_pend clears is captured without overflow.
- Reset mid-access: FSM returns to IDLE immediately. Any in-flight rvalid is dropped. The pending write is lost; spi_ovf is not set.

Test Plan:
- Single SPI write: toggle 0->1 with addr 0x05, data 0xA5 -> exactly one rf write (rf_addr 0x05, rf_wdata 0xA5), 3 cycles after the toggle; spi_ovf = 0.
- Core read: core_req, core_we = 0, addr 0x10; rf model returns 0x3C -> ready at cycle 0, rf_en at cycle 1, rvalid with rdata 0x3C at cycle 2.
- Contention:
  - Setup: SPI write pending and core_req held continuously; pointer starts at SPI.
  - Required: grant order SPI, then core.
  - Then, after a new SPI toggle: grant order alternates core, SPI.
  - Every write lands exactly once.
- Overflow: two toggles 1 cycle apart while core holds the port -> first write (addr 0x01) committed, second dropped, spi_ovf = 1 until reset.
- Out of range, NUM_REGS = 32:
  - Core read of addr 0x28 -> no rf_en; rvalid with rdata 0x00 and core_err = 1.
  - SPI write to 0x30 -> no rf_en; busy clears.
- Reset during READ: rst_n low in the rf_en cycle -> all outputs 0 immediately; no core_rvalid after release; FSM in IDLE.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares the single-port register file between the SPI bridge write path
//   and a core-side requester. The bridge signals each write with an edge on
//   spi_wr_toggle (resynchronised into sclk). The core uses a req/ready
//   handshake. Requesters are served round-robin, and each access is
//   sequenced by a four-state FSM.
//
// Ports
//   sclk, rst_n         clock, asynchronous active-low reset
//   spi_wr_toggle       bridge write event (every edge is one write)
//   spi_wr_addr/data    bridge write address/data, stable while in flight
//   core_req/we         core request, 1 = write / 0 = read
//   core_addr/wdata     core address / write data
//   core_ready          core request accepted this cycle
//   core_rvalid/rdata   core read data, 1-cycle valid pulse
//   core_err            out-of-range core access (with ready or rvalid)
//   rf_en/we/addr/wdata register-file strobe, write enable, address, data
//   rf_rdata            register-file read data, valid 1 cycle after rf_en
//   spi_ovf             sticky flag: a bridge write was lost
//   busy                FSM active or a bridge write pending
module regfile_port_arbiter #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              spi_wr_toggle,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ready,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              spi_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] RANGE_LIM = (ADDR_W + 1)'(NUM_REGS);

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= RANGE_LIM);
  endfunction

  // Bridge path state
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   spi_edge;
  logic                   spi_pend_q;
  logic                   spi_ovf_q;
  logic [ADDR_W-1:0]      hold_addr_q;
  logic [DATA_W-1:0]      hold_data_q;
  logic                   spi_clr;

  // Arbitration / access state
  state_t            state_q, state_d;
  logic              rr_q, rr_d;              // 0 = SPI next, 1 = core next
  logic              acc_spi_q, acc_spi_d;
  logic              acc_oor_q, acc_oor_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_spi, grant_core;
  logic              spi_oor, core_oor;
  logic [DATA_W-1:0] rd_val;

  assign spi_edge = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
  assign spi_oor  = out_of_range(hold_addr_q);
  assign core_oor = out_of_range(core_addr);

  // A new edge in the cycle the held write retires is captured cleanly;
  // only an edge arriving while the held write is still owed overflows.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      spi_pend_q  <= 1'b0;
      spi_ovf_q   <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], spi_wr_toggle};
      if (spi_edge) begin
        if (spi_pend_q && !spi_clr) begin
          spi_ovf_q <= 1'b1;
        end else begin
          hold_addr_q <= spi_wr_addr;
          hold_data_q <= spi_wr_data;
          spi_pend_q  <= 1'b1;
        end
      end else if (spi_clr) begin
        spi_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      acc_spi_q  <= 1'b0;
      acc_oor_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      acc_spi_q  <= acc_spi_d;
      acc_oor_q  <= acc_oor_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign grant_spi  = spi_pend_q && (!core_req || !rr_q);
  assign grant_core = core_req && !grant_spi;

  // rf_* registers load only for in-range accesses, so they hold their last
  // values whenever rf_en is low (including out-of-range cycles).
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    acc_spi_d   = acc_spi_q;
    acc_oor_d   = acc_oor_q;
    rf_we_d     = rf_we_q;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    rdata_d     = rdata_q;
    rd_val      = rdata_q;
    core_ready  = 1'b0;
    core_rvalid = 1'b0;
    core_err    = 1'b0;
    rf_en       = 1'b0;
    spi_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_spi) begin
          rr_d      = 1'b1;
          acc_spi_d = 1'b1;
          acc_oor_d = spi_oor;
          if (!spi_oor) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = hold_addr_q;
            rf_wdata_d = hold_data_q;
          end
          state_d = S_WRITE;
        end else if (grant_core) begin
          rr_d       = 1'b0;
          acc_spi_d  = 1'b0;
          acc_oor_d  = core_oor;
          core_ready = 1'b1;
          core_err   = core_we && core_oor;
          if (!core_oor) begin
            rf_we_d   = core_we;
            rf_addr_d = core_addr;
            if (core_we) rf_wdata_d = core_wdata;
          end
          state_d = core_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        rf_en   = !acc_oor_q;
        spi_clr = acc_spi_q;
        state_d = S_IDLE;
      end
      S_READ: begin
        rf_en   = !acc_oor_q;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        rd_val      = acc_oor_q ? '0 : rf_rdata;
        rdata_d     = rd_val;
        core_rvalid = 1'b1;
        core_err    = acc_oor_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_rdata = rd_val;
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wdata   = rf_wdata_q;
  assign spi_ovf    = spi_ovf_q;
  assign busy       = (state_q != S_IDLE) || spi_pend_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  logic       sclk;
  logic       rst_n;
  logic       spi_wr_toggle;
  logic [5:0] spi_wr_addr;
  logic [7:0] spi_wr_data;
  logic       core_req;
  logic       core_we;
  logic [5:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_ready;
  logic       core_rvalid;
  logic [7:0] core_rdata;
  logic       core_err;
  logic       rf_en;
  logic       rf_we;
  logic [5:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;
  logic       spi_ovf;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
  } rf_t;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } rd_t;

  rf_t exp_rf[$];
  rd_t exp_rd[$];

  regfile_port_arbiter #(
    .ADDR_W     (6),
    .DATA_W     (8),
    .NUM_REGS   (32),
    .SYNC_STAGES(2)
  ) dut (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .spi_wr_toggle(spi_wr_toggle),
    .spi_wr_addr  (spi_wr_addr),
    .spi_wr_data  (spi_wr_data),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_ready   (core_ready),
    .core_rvalid  (core_rvalid),
    .core_rdata   (core_rdata),
    .core_err     (core_err),
    .rf_en        (rf_en),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_wdata     (rf_wdata),
    .rf_rdata     (rf_rdata),
    .spi_ovf      (spi_ovf),
    .busy         (busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Register-file model: read data is a fixed function of the address.
  always @(posedge sclk) begin
    if (rf_en && !rf_we) rf_rdata <= {2'b00, rf_addr} ^ 8'h2C;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic rf_t mk_rf(input logic we, input logic [5:0] a, input logic [7:0] d);
    rf_t r;
    r.we = we; r.addr = a; r.data = d;
    return r;
  endfunction

  function automatic rd_t mk_rd(input logic [7:0] d, input logic e);
    rd_t r;
    r.data = d; r.err = e;
    return r;
  endfunction

  function automatic logic [31:0] all_outs();
    return {3'b000, rf_en, rf_we, rf_addr, rf_wdata, core_ready, core_rvalid,
            core_rdata, core_err, spi_ovf, busy};
  endfunction

  // Scoreboard: every rf access and every read response must match the
  // oldest expectation queued when the stimulus was driven.
  always @(negedge sclk) begin
    if (rst_n) begin
      if (rf_en) begin
        if (exp_rf.size() == 0) begin
          check("rf_unexpected", exp_rf.size(), 1);
        end else begin
          rf_t e;
          e = exp_rf.pop_front();
          check("rf_we", rf_we, e.we);
          check("rf_addr", rf_addr, e.addr);
          if (e.we) check("rf_wdata", rf_wdata, e.data);
        end
      end
      if (core_rvalid) begin
        if (exp_rd.size() == 0) begin
          check("rvalid_unexpected", exp_rd.size(), 1);
        end else begin
          rd_t e;
          e = exp_rd.pop_front();
          check("core_rdata", core_rdata, e.data);
          check("core_err_rd", core_err, e.err);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; spi_wr_toggle = 1'b0; spi_wr_addr = '0; spi_wr_data = '0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;

    // Reset state
    @(negedge sclk); #1;
    check("reset_outs", all_outs(), 32'h0);
    @(negedge sclk); rst_n = 1'b1;

    // Single SPI write: rf write lands 3 cycles after the toggle
    @(negedge sclk);
    spi_wr_toggle = 1'b1; spi_wr_addr = 6'h05; spi_wr_data = 8'hA5;
    exp_rf.push_back(mk_rf(1'b1, 6'h05, 8'hA5));
    for (int k = 1; k <= 3; k++) begin
      @(negedge sclk); #1;
      check($sformatf("spi_lat_c%0d", k), rf_en, (k == 3));
      if (k == 2) check("spi_busy_pend", busy, 1);
    end
    @(negedge sclk); #1;
    check("spi_done_rf_en", rf_en, 0);
    check("spi_done_busy", busy, 0);
    check("spi_no_ovf", spi_ovf, 0);

    // Core read of 0x10 -> 0x3C
    @(negedge sclk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h10;
    exp_rf.push_back(mk_rf(1'b0, 6'h10, 8'h00));
    exp_rd.push_back(mk_rd(8'h3C, 1'b0));
    #1 check("rd_ready_c0", core_ready, 1);
    @(negedge sclk); core_req = 1'b0; #1;
    check("rd_rf_en_c1", rf_en, 1);
    check("rd_rvalid_c1", core_rvalid, 0);
    @(negedge sclk); #1;
    check("rd_rvalid_c2", core_rvalid, 1);
    check("rd_rdata_c2", core_rdata, 8'h3C);

    // Contention: pointer at SPI, SPI pending and core held
    @(negedge sclk);
    spi_wr_toggle = 1'b0; spi_wr_addr = 6'h07; spi_wr_data = 8'h11;
    exp_rf.push_back(mk_rf(1'b1, 6'h07, 8'h11));
    @(negedge sclk);
    @(negedge sclk);
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'h08; core_wdata = 8'h22;
    exp_rf.push_back(mk_rf(1'b1, 6'h08, 8'h22));
    #1 check("ct_spi_first", core_ready, 0);
    @(negedge sclk); #1 check("ct_spi_write", rf_en, 1);
    @(negedge sclk); #1 check("ct_core_second", core_ready, 1);
    @(negedge sclk);
    core_addr = 6'h09; core_wdata = 8'h33;
    exp_rf.push_back(mk_rf(1'b1, 6'h09, 8'h33));
    spi_wr_toggle = 1'b1; spi_wr_addr = 6'h0A; spi_wr_data = 8'h44;
    exp_rf.push_back(mk_rf(1'b1, 6'h0A, 8'h44));
    #1 check("ct_busy_no_ready", core_ready, 0);
    @(negedge sclk); #1 check("ct2_core_first", core_ready, 1);
    @(negedge sclk);
    core_addr = 6'h0B; core_wdata = 8'h55;
    exp_rf.push_back(mk_rf(1'b1, 6'h0B, 8'h55));
    #1 check("ct2_write_no_ready", core_ready, 0);
    @(negedge sclk); #1 check("ct2_spi_wins", core_ready, 0);
    @(negedge sclk); #1 check("ct2_spi_write", core_ready, 0);
    @(negedge sclk); #1 check("ct2_core_again", core_ready, 1);
    @(negedge sclk); core_req = 1'b0;
    @(negedge sclk); #1;
    check("ct_idle", busy, 0);
    check("ct_all_landed", exp_rf.size(), 0);

    // Overflow: two toggles one cycle apart while core holds the port
    @(negedge sclk);
    spi_wr_toggle = 1'b0; spi_wr_addr = 6'h01; spi_wr_data = 8'h66;
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'h03; core_wdata = 8'h88;
    exp_rf.push_back(mk_rf(1'b1, 6'h03, 8'h88));
    exp_rf.push_back(mk_rf(1'b1, 6'h01, 8'h66));
    #1 check("ovf_core_ready", core_ready, 1);
    @(negedge sclk); core_req = 1'b0; spi_wr_toggle = 1'b1;
    @(negedge sclk); spi_wr_addr = 6'h02; spi_wr_data = 8'h77;
    #1 check("ovf_not_yet", spi_ovf, 0);
    @(negedge sclk); #1;
    check("ovf_set", spi_ovf, 1);
    check("ovf_first_commit", rf_en, 1);
    for (int k = 0; k < 3; k++) @(negedge sclk);
    #1;
    check("ovf_sticky", spi_ovf, 1);
    check("ovf_one_write", exp_rf.size(), 0);
    check("ovf_idle", busy, 0);

    // Out of range core write (NUM_REGS = 32)
    @(negedge sclk);
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'h20; core_wdata = 8'h99;
    #1;
    check("oor_wr_ready", core_ready, 1);
    check("oor_wr_err", core_err, 1);
    @(negedge sclk); core_req = 1'b0; #1;
    check("oor_wr_no_rf", rf_en, 0);

    // Out of range core read of 0x28
    @(negedge sclk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h28;
    exp_rd.push_back(mk_rd(8'h00, 1'b1));
    #1;
    check("oor_rd_ready", core_ready, 1);
    check("oor_rd_no_err_at_ready", core_err, 0);
    @(negedge sclk); core_req = 1'b0; #1;
    check("oor_rd_no_rf", rf_en, 0);
    @(negedge sclk); #1;
    check("oor_rd_rvalid", core_rvalid, 1);
    check("oor_rd_err", core_err, 1);
    check("oor_rd_rdata", core_rdata, 8'h00);

    // Out of range SPI write to 0x30 is dropped silently
    @(negedge sclk);
    spi_wr_toggle = 1'b0; spi_wr_addr = 6'h30; spi_wr_data = 8'hC3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sclk); #1;
      check($sformatf("oor_spi_no_rf_c%0d", k), rf_en, 0);
      check($sformatf("oor_spi_busy_c%0d", k), busy, (k == 2 || k == 3));
    end
    check("oor_spi_ovf_kept", spi_ovf, 1);

    // Reset during the READ (rf_en) cycle
    @(negedge sclk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h10;
    #1 check("rst_rd_ready", core_ready, 1);
    @(posedge sclk); #2;
    check("rst_rd_rf_en", rf_en, 1);
    rst_n = 1'b0; core_req = 1'b0;
    #1 check("rst_mid_outs", all_outs(), 32'h0);
    @(negedge sclk); rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge sclk); #1;
      check($sformatf("rst_no_rvalid_c%0d", k), core_rvalid, 0);
      check($sformatf("rst_idle_c%0d", k), busy, 0);
    end

    // Normal read after reset: FSM starts from IDLE
    @(negedge sclk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h11;
    exp_rf.push_back(mk_rf(1'b0, 6'h11, 8'h00));
    exp_rd.push_back(mk_rd(8'h3D, 1'b0));
    #1 check("post_rst_ready", core_ready, 1);
    @(negedge sclk); core_req = 1'b0; #1;
    check("post_rst_rf_en", rf_en, 1);
    @(negedge sclk); #1;
    check("post_rst_rvalid", core_rvalid, 1);
    @(negedge sclk); #1;
    check("final_rf_queue", exp_rf.size(), 0);
    check("final_rd_queue", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
